// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : RV32M multiply/divide unit. 32-step shift-add multiply and
//            restoring divide, with one-edge special cases.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter bit MUL_FAST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_flush,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_func;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_done;
    logic [31:0] r_result;
    logic [63:0] r_acc;
    logic [63:0] r_opa;
    logic [31:0] r_opb;

    logic        w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_div0, w_ovf, w_fast;
    logic [63:0] w_fast_prod;
    logic [31:0] w_fast_res;
    logic [63:0] w_mul_acc, w_div_acc, w_acc_nx, w_prod;
    logic [32:0] w_shift;
    logic [31:0] w_sub, w_quo, w_rem, w_slow_res;
    logic        w_ge;

    // Operand decode straight from the EX-stage inputs at the accept edge
    assign w_is_div   = func3[2];
    assign w_a_signed = w_is_div ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
    assign w_b_signed = w_is_div ? ~func3[0] : (func3[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed & op1[31];
    assign w_b_neg    = w_b_signed & op2[31];
    // Unsigned 32-bit magnitudes: -0x80000000 wraps to 0x80000000, which is exact
    assign w_a_mag    = w_a_neg ? -op1 : op1;
    assign w_b_mag    = w_b_neg ? -op2 : op2;
    assign w_div0     = w_is_div & (op2 == 32'd0);
    assign w_ovf      = w_is_div & ~func3[0] & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
    assign w_fast     = w_div0 | w_ovf | (~w_is_div & MUL_FAST);

    generate
        if (MUL_FAST) begin : g_mul_fast
            logic [63:0] w_mag_prod;
            assign w_mag_prod  = {32'd0, w_a_mag} * {32'd0, w_b_mag};
            assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_mag_prod : w_mag_prod;
        end else begin : g_mul_iter
            assign w_fast_prod = 64'd0;
        end
    endgenerate

    always_comb begin
        if (w_div0)
            w_fast_res = func3[1] ? op1 : 32'hFFFF_FFFF;
        else if (w_ovf)
            w_fast_res = func3[1] ? 32'h0000_0000 : 32'h8000_0000;
        else if (func3[1:0] == 2'b00)
            w_fast_res = w_fast_prod[31:0];
        else
            w_fast_res = w_fast_prod[63:32];
    end

    // One iteration: multiply adds the shifted multiplicand; divide holds {rem, quo}
    assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : 64'd0);
    assign w_shift   = {r_acc[63:32], r_acc[31]};
    assign w_ge      = (w_shift >= {1'b0, r_opa[31:0]});
    assign w_sub     = w_shift[31:0] - r_opa[31:0];
    assign w_div_acc = {(w_ge ? w_sub : w_shift[31:0]), r_acc[30:0], w_ge};
    assign w_acc_nx  = r_func[2] ? w_div_acc : w_mul_acc;

    always_comb begin
        w_prod = r_neg_q ? -w_acc_nx : w_acc_nx;
        w_quo  = r_neg_q ? -w_acc_nx[31:0] : w_acc_nx[31:0];
        w_rem  = r_neg_r ? -w_acc_nx[63:32] : w_acc_nx[63:32];
        case (r_func)
            3'b000:                 w_slow_res = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_slow_res = w_prod[63:32];
            3'b100, 3'b101:         w_slow_res = w_quo;
            default:                w_slow_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_func   <= 3'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_acc    <= 64'd0;
            r_opa    <= 64'd0;
            r_opb    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (pipeline_flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_func  <= func3;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= 5'd0;
                            if (w_fast) begin
                                r_state  <= DONE;
                                r_done   <= 1'b1;
                                r_result <= w_fast_res;
                            end else begin
                                r_state <= BUSY;
                                r_acc   <= w_is_div ? {32'd0, w_a_mag} : 64'd0;
                                r_opa   <= w_is_div ? {32'd0, w_b_mag} : {32'd0, w_a_mag};
                                r_opb   <= w_is_div ? 32'd0 : w_b_mag;
                            end
                        end
                    end
                    BUSY: begin
                        r_acc <= w_acc_nx;
                        r_opa <= r_func[2] ? r_opa : {r_opa[62:0], 1'b0};
                        r_opb <= {1'b0, r_opb[31:1]};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= w_slow_res;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign stall  = ~rst & (((r_state == IDLE) & start & ~pipeline_flush) | (r_state == BUSY));
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit: directed vectors for muldiv_unit, checked every cycle against
// an arithmetic reference model plus hand-computed literal results.
module tb_muldiv_unit;
    localparam bit C_MUL_FAST = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipeline_flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    bit checking = 1'b0;

    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pending = 32'd0;

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_FAST(C_MUL_FAST)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipeline_flush (pipeline_flush),
        .start          (start),
        .func3          (func3),
        .op1            (op1),
        .op2            (op2),
        .stall          (stall),
        .done           (done),
        .result         (result)
    );

    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] s1, s2, sq;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        s1 = a;
        s2 = b;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = s1 / s2;
                return sq;
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = s1 % s2;
                return sq;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit model_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return C_MUL_FAST;
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: accepted op is either done at the accept edge or 32 edges later
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (pipeline_flush) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end
            end else if (!m_done && start) begin
                if (model_fast(func3, op1, op2)) begin
                    m_done   <= 1'b1;
                    m_result <= model_res(func3, op1, op2);
                end else begin
                    m_left    <= 32;
                    m_pending <= model_res(func3, op1, op2);
                end
            end
        end
    end

    function automatic bit exp_stall();
        if (rst) return 1'b0;
        return (m_left > 0) || (m_left == 0 && !m_done && start && !pipeline_flush);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (checking) begin
            check("cyc_stall", {31'd0, stall}, {31'd0, exp_stall()});
            check("cyc_done", {31'd0, done}, {31'd0, m_done});
            check("cyc_result", result, m_result);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int stalls = 0;
        bit seen = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b1; func3 = f; op1 = a; op2 = b;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (stall === 1'b1) stalls++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_result"}, result, exp);
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        int d0;
        start = 1'b1; func3 = 3'b000; op1 = 32'd7; op2 = 32'hFFFF_FFFD;
        @(posedge clk);
        checking = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0; start = 1'b0;

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        run_op("div_min_2", 3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
        run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'h0000_0005, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("remu_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33);

        // Flush while the counter reads 10
        @(posedge clk);
        #2;
        start = 1'b1; func3 = 3'b101; op1 = 32'd100; op2 = 32'd7;
        repeat (11) @(posedge clk);
        #2;
        start = 1'b0; pipeline_flush = 1'b1;
        @(posedge clk);
        #2;
        pipeline_flush = 1'b0;
        d0 = n_done;
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(n_done - d0), 32'd0);
        check("flush_result_kept", result, 32'h0000_0001);
        run_op("div_after_flush", 3'b100, 32'd100, 32'd7, 32'h0000_000E, 33);

        // Asynchronous reset while the counter reads 20
        @(posedge clk);
        #2;
        start = 1'b1; func3 = 3'b000; op1 = 32'd7; op2 = 32'hFFFF_FFFD;
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0; start = 1'b0;
        d0 = n_done;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);

        // Back-to-back with start held high through each DONE cycle
        d0 = n_done;
        run_op("b2b_mul", 3'b000, 32'd3, 32'd5, 32'h0000_000F, 33);
        run_op("b2b_div", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_done_count", 32'(n_done - d0), 32'd2);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
